// File: rtl/fft_pkg.sv
// Shared defaults, FSM state encoding and address helper for the FFT result reader.
// Optional FFT_BITREV_EN (see fft_result_reader) selects bit-reversed RAM addressing.
package fft_pkg;

  localparam int unsigned FFT_N      = 8;
  localparam int unsigned FFT_ADDR_W = 3;
  localparam int unsigned FFT_DW     = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Two-entry output FIFO holding {re, im, index, last}; head is visible while not empty.
module fft_out_fifo #(
  parameter int unsigned W = 2 * fft_pkg::FFT_DW + fft_pkg::FFT_ADDR_W + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fft_result_reader.sv
// Walks the FFT result RAM after flag_fftfinish rises and streams N bins on valid/ready.
// Define FFT_BITREV_EN to address the RAM in bit-reversed order (m_index stays natural).
module fft_result_reader
  import fft_pkg::*;
#(
  parameter int unsigned N      = FFT_N,
  parameter int unsigned ADDR_W = FFT_ADDR_W,
  parameter int unsigned DW     = FFT_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flag_fftfinish,
  output logic [ADDR_W-1:0]        read_addr,
  input  logic signed [DW-1:0]     dataout_re,
  input  logic signed [DW-1:0]     dataout_im,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DW-1:0]     m_re,
  output logic signed [DW-1:0]     m_im,
  output logic [ADDR_W-1:0]        m_index,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned EW = 2 * DW + ADDR_W + 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic                flag_q;
  logic                inflight_q;
  logic [ADDR_W-1:0]   infl_k_q;
  logic                infl_last_q;

  logic                rise;
  logic                issue;
  logic                can_issue;
  logic                k_is_last;
  logic [2:0]          used;

  logic [EW-1:0]       push_data;
  logic [EW-1:0]       head;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [1:0]          fifo_count;

  assign rise      = flag_fftfinish && !flag_q;
  assign k_is_last = (k_q == ADDR_W'(N - 1));

  // Credit counts the head leaving this cycle, so a full-rate stream never stalls.
  assign used      = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign can_issue = (used < (3'd2 + {2'b00, fifo_pop})) && !(fifo_full && !fifo_pop);

`ifdef FFT_BITREV_EN
  assign read_addr = ADDR_W'(bitrev(32'(k_q), ADDR_W));
`else
  assign read_addr = k_q;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = READ;
          k_d     = '0;
        end
      end
      READ: begin
        if (can_issue) begin
          issue = 1'b1;
          k_d   = k_q + ADDR_W'(1);
          if (k_is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !inflight_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      flag_q      <= 1'b0;
      inflight_q  <= 1'b0;
      infl_k_q    <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      flag_q     <= flag_fftfinish;
      inflight_q <= issue;
      if (issue) begin
        infl_k_q    <= k_q;
        infl_last_q <= k_is_last;
      end
    end
  end

  assign push_data = {dataout_re, dataout_im, infl_k_q, infl_last_q};
  assign fifo_pop  = m_valid && m_ready;

  fft_out_fifo #(
    .W (EW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (inflight_q),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign m_re    = head[EW-1 -: DW];
  assign m_im    = head[EW-1-DW -: DW];
  assign m_index = head[ADDR_W:1];
  assign m_last  = head[0];
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fft_result_reader.sv
// Self-checking bench for fft_result_reader: RAM model, bin table, scoreboard and corner sequences.
module tb_fft_result_reader;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flag;
  logic [AW-1:0]        read_addr;
  logic signed [DW-1:0] dre, dim;
  logic                 m_valid, m_ready;
  logic signed [DW-1:0] m_re, m_im;
  logic [AW-1:0]        m_index;
  logic                 m_last, busy, done;

  always #10 clk = ~clk;

  fft_result_reader #(.N(N), .ADDR_W(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flag_fftfinish (flag),
    .read_addr      (read_addr),
    .dataout_re     (dre),
    .dataout_im     (dim),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_re           (m_re),
    .m_im           (m_im),
    .m_index        (m_index),
    .m_last         (m_last),
    .busy           (busy),
    .done           (done)
  );

  // Core RAM model: one cycle read latency.
  logic signed [DW-1:0] ram_re [N];
  logic signed [DW-1:0] ram_im [N];
  always @(posedge clk) begin
    dre <= ram_re[read_addr];
    dim <= ram_im[read_addr];
  end

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [AW-1:0]        idx;
    logic                 last;
  } exp_t;

  typedef struct {
    logic [AW-1:0]        k;
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 last;
  } vec_t;

  exp_t sbq[$];
  vec_t vec[N];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int bins_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] tb_bitrev(input logic [AW-1:0] k);
    logic [AW-1:0] r;
    for (int i = 0; i < int'(AW); i++) r[i] = k[int'(AW)-1-i];
    return r;
  endfunction

  task automatic build_vec();
    logic [AW-1:0] k;
    logic [AW-1:0] a;
    for (int i = 0; i < int'(N); i++) begin
      k = AW'(i);
`ifdef FFT_BITREV_EN
      a = tb_bitrev(k);
`else
      a = k;
`endif
      vec[i].k    = k;
      vec[i].addr = a;
      vec[i].re   = ram_re[a];
      vec[i].im   = ram_im[a];
      vec[i].last = (i == int'(N) - 1);
    end
  endtask

  // Pushes the expected bins, then raises the flag just after a rising edge.
  task automatic start_frame();
    exp_t e;
    for (int i = 0; i < int'(N); i++) begin
      e.re = vec[i].re; e.im = vec[i].im; e.idx = vec[i].k; e.last = vec[i].last;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 flag = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    base = done_cnt;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (done_cnt > base) break;
    end
    chk({tag, "_done_count"}, 64'(done_cnt), 64'(base + 1));
    chk({tag, "_sb_drained"}, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    logic                 stalled;
    logic signed [DW-1:0] h_re, h_im;
    logic [AW-1:0]        h_idx;
    logic                 h_last;
    int                   base;

    rst = 1'b0; flag = 1'b0; m_ready = 1'b1;
    for (int a = 0; a < int'(N); a++) begin
      ram_re[a] = DW'(100 * a);
      ram_im[a] = DW'(-a);
    end
    build_vec();

    stalled = 1'b0;
    h_re = '0; h_im = '0; h_idx = '0; h_last = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          stalled = 1'b0;
        end else begin
          if (done) done_cnt++;
          if (stalled) begin
            chk("stall_valid_held", 64'(m_valid), 64'd1);
            chk("stall_re_stable",  64'(m_re),    64'(h_re));
            chk("stall_im_stable",  64'(m_im),    64'(h_im));
            chk("stall_idx_stable", 64'(m_index), 64'(h_idx));
            chk("stall_last_stable",64'(m_last),  64'(h_last));
          end
          if (m_valid && m_ready) begin
            chk("bin_expected", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
              exp_t e;
              e = sbq.pop_front();
              chk("bin_re",    64'(m_re),    64'(e.re));
              chk("bin_im",    64'(m_im),    64'(e.im));
              chk("bin_index", 64'(m_index), 64'(e.idx));
              chk("bin_last",  64'(m_last),  64'(e.last));
            end
            bins_seen++;
          end
          stalled = m_valid && !m_ready;
          if (stalled) begin
            h_re = m_re; h_im = m_im; h_idx = m_index; h_last = m_last;
          end
        end
      end
    join_none

    // Reset state while rst is held low.
    #5;
    chk("rst_read_addr", 64'(read_addr), 64'd0);
    chk("rst_m_valid",   64'(m_valid),   64'd0);
    chk("rst_m_re",      64'(m_re),      64'd0);
    chk("rst_m_im",      64'(m_im),      64'd0);
    chk("rst_m_index",   64'(m_index),   64'd0);
    chk("rst_m_last",    64'(m_last),    64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Full-rate frame: exact address sequence and done timing.
    start_frame();
    @(negedge clk);
    chk("f1_busy_edge_cycle", 64'(busy), 64'd0);
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      chk("f1_read_addr", 64'(read_addr), 64'(vec[i].addr));
      chk("f1_busy", 64'(busy), 64'd1);
    end
    for (int j = int'(N) + 1; j <= int'(N) + 3; j++) begin
      @(negedge clk);
      chk("f1_done_timing", 64'(done), 64'(j == int'(N) + 3));
    end
    chk("f1_sb_drained", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1 flag = 1'b0;
    chk("f1_busy_after", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);

    // Backpressure: ready low in stream cycles 3-6, then random.
    start_frame();
    base = done_cnt;
    for (int c = 1; c < 300; c++) begin
      @(posedge clk);
      #1 m_ready = (c >= 3 && c <= 6) ? 1'b0 : 1'($urandom_range(0, 1));
      if (done_cnt > base) break;
    end
    chk("stall_done_count", 64'(done_cnt), 64'(base + 1));
    chk("stall_sb_drained", 64'(sbq.size()), 64'd0);
    m_ready = 1'b1;
    flag = 1'b0;
    repeat (2) @(posedge clk);

    // Flag held high 30 cycles with a mid-frame drop and second rising edge.
    base = done_cnt;
    start_frame();
    for (int c = 1; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) flag = 1'b0;
      if (c == 5) flag = 1'b1;
    end
    chk("hold_one_done", 64'(done_cnt), 64'(base + 1));
    chk("hold_sb_drained", 64'(sbq.size()), 64'd0);
    chk("hold_idle", 64'(busy), 64'd0);
    chk("hold_no_valid", 64'(m_valid), 64'd0);
    flag = 1'b0;
    repeat (2) @(posedge clk);

    // Reset after bin 3 accepted: immediate clear, no done, clean restart.
    base = bins_seen;
    start_frame();
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      if (bins_seen >= base + 4) break;
    end
    chk("rstmid_bins_before", 64'(bins_seen - base), 64'd4);
    base = done_cnt;
    #2 rst = 1'b0;
    #1;
    chk("rstmid_read_addr", 64'(read_addr), 64'd0);
    chk("rstmid_m_valid",   64'(m_valid),   64'd0);
    chk("rstmid_m_re",      64'(m_re),      64'd0);
    chk("rstmid_m_im",      64'(m_im),      64'd0);
    chk("rstmid_m_index",   64'(m_index),   64'd0);
    chk("rstmid_m_last",    64'(m_last),    64'd0);
    chk("rstmid_busy",      64'(busy),      64'd0);
    chk("rstmid_done",      64'(done),      64'd0);
    sbq.delete();
    flag = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    chk("rstmid_no_done", 64'(done_cnt), 64'(base));
    start_frame();
    wait_done("restart", 40);
    @(posedge clk);
    #1 flag = 1'b0;
    repeat (2) @(posedge clk);

    // Signed extremes at address 5.
    ram_re[5] = 24'sh800000;
    ram_im[5] = 24'sh7FFFFF;
    build_vec();
    start_frame();
    wait_done("extreme", 40);
    @(posedge clk);
    #1 flag = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
